gb_bus_master: RTL

- Initiator side of the DMG cartridge bus: generates CPU-style read/write machine cycles (A0-A14, A15 chip select, nRD, nWR, D0-D7) toward a real cartridge or ROM responder.
- Used to dump and probe cartridges from the FPGA, and to bench-test our ROM-responder logic back-to-back.
- Host logic issues single transactions over a valid/ready request port and receives read data on a one-cycle response strobe.

---
 rtl/gb_bus_pkg.sv | 23 ++
 rtl/gb_bus_master_if.sv | 34 +++
 rtl/gb_bus_master.sv | 117 +++++++++++
 3 files changed

// File: rtl/gb_bus_pkg.sv
// Shared definitions for the DMG cartridge bus: machine-cycle states,
// memory map constants and the cartridge chip-select decode.
package gb_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3
    } bus_state_t;

    localparam logic [15:0] ROM_END    = 16'h7FFF;
    localparam logic [15:0] XRAM_BASE  = 16'hA000;
    localparam logic [15:0] XRAM_END   = 16'hBFFF;
    localparam logic [15:0] BOOT_ENTRY = 16'h0100;

    // True when the address falls in cartridge ROM or cartridge external RAM.
    function automatic logic cs_hit(input logic [15:0] adr);
        return (adr <= ROM_END) || ((adr >= XRAM_BASE) && (adr <= XRAM_END));
    endfunction

endpackage

// File: rtl/gb_bus_master_if.sv
// Cartridge-side bus bundle: A0-A14, A15 chip select, strobes and D0-D7.
// The master drives address/strobes/data; the slave (cartridge or ROM
// responder) returns the sampled data byte.
interface gb_bus_master_if;

    logic [14:0] adr_out;
    logic        n_cs;
    logic        n_rd;
    logic        n_wr;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;

    modport master (
        output adr_out,
        output n_cs,
        output n_rd,
        output n_wr,
        output data_out,
        output data_oe,
        input  data_in
    );

    modport slave (
        input  adr_out,
        input  n_cs,
        input  n_rd,
        input  n_wr,
        input  data_out,
        input  data_oe,
        output data_in
    );

endinterface

// File: rtl/gb_bus_master.sv
// Initiator for the DMG cartridge bus. Turns single host requests into
// CPU-style read/write machine cycles of four phases (T0..T3), each
// PHASE_CLKS clocks long. All bus outputs come straight from flops so the
// strobes cannot glitch; an IDLE clock between cycles gives bus turnaround.
module gb_bus_master
    import gb_bus_pkg::*;
#(
    parameter int PHASE_CLKS = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             n_reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [15:0]      req_adr,
    input  logic [7:0]       req_wdata,

    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,

    gb_bus_master_if.master  bus,

    output logic [CNT_W-1:0] txn_count
);

    localparam int PH_W = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_CLKS - 1);

    bus_state_t      state;
    logic [PH_W-1:0] phase;
    logic            wr_q;
    logic [7:0]      wdata_q;

    // Machine-cycle sequencer: phase timing, strobes, write data and completion.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            phase        <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            bus.adr_out  <= '0;
            bus.n_cs     <= 1'b1;
            bus.n_rd     <= 1'b1;
            bus.n_wr     <= 1'b1;
            bus.data_out <= '0;
            bus.data_oe  <= 1'b0;
            txn_count    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state       <= T0;
                        phase       <= '0;
                        wr_q        <= req_write;
                        wdata_q     <= req_wdata;
                        req_ready   <= 1'b0;
                        bus.adr_out <= req_adr[14:0];
                        bus.n_cs    <= !cs_hit(req_adr);
                        // Reads hold nRD low for the whole cycle; writes never assert it.
                        bus.n_rd    <= req_write;
                        bus.n_wr    <= 1'b1;
                        bus.data_oe <= 1'b0;
                    end
                end
                default: begin
                    if (phase != PH_LAST) begin
                        phase <= phase + PH_W'(1);
                    end else begin
                        phase <= '0;
                        case (state)
                            T0: begin
                                state <= T1;
                                // One phase of data setup before nWR falls.
                                if (wr_q) begin
                                    bus.data_oe  <= 1'b1;
                                    bus.data_out <= wdata_q;
                                end
                            end
                            T1: begin
                                state <= T2;
                                if (wr_q) begin
                                    bus.n_wr <= 1'b0;
                                end
                            end
                            T2: begin
                                state    <= T3;
                                bus.n_wr <= 1'b1;
                            end
                            T3: begin
                                state       <= IDLE;
                                req_ready   <= 1'b1;
                                rsp_valid   <= 1'b1;
                                txn_count   <= txn_count + CNT_W'(1);
                                bus.n_cs    <= 1'b1;
                                bus.n_rd    <= 1'b1;
                                bus.data_oe <= 1'b0;
                                if (!wr_q) begin
                                    rsp_rdata <= bus.data_in;
                                end
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
